acc_icb_arb: RTL and testbench

ACC_ICB_ARB -- requirements
Module: acc_icb_arb

---
 rtl/acc_icb_arb.sv | 119 +++++++++++
 tb/tb_acc_icb_arb.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_icb_arb.sv
// Two-requester ICB arbiter: round-robin command grant with a stall lock, and
// in-order response routing driven by a FIFO of issuing-requester tags.
module acc_icb_arb #(
  parameter int unsigned OST_DEPTH = 4,
  parameter int unsigned AW        = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         m0_icb_cmd_valid,
  output logic                         m0_icb_cmd_ready,
  input  logic                         m0_icb_cmd_read,
  input  logic [AW-1:0]                m0_icb_cmd_addr,
  input  logic [31:0]                  m0_icb_cmd_wdata,
  input  logic [3:0]                   m0_icb_cmd_wmask,
  output logic                         m0_icb_rsp_valid,
  input  logic                         m0_icb_rsp_ready,
  output logic [31:0]                  m0_icb_rsp_rdata,
  output logic                         m0_icb_rsp_err,
  input  logic                         m1_icb_cmd_valid,
  output logic                         m1_icb_cmd_ready,
  input  logic                         m1_icb_cmd_read,
  input  logic [AW-1:0]                m1_icb_cmd_addr,
  input  logic [31:0]                  m1_icb_cmd_wdata,
  input  logic [3:0]                   m1_icb_cmd_wmask,
  output logic                         m1_icb_rsp_valid,
  input  logic                         m1_icb_rsp_ready,
  output logic [31:0]                  m1_icb_rsp_rdata,
  output logic                         m1_icb_rsp_err,
  output logic                         s_icb_cmd_valid,
  input  logic                         s_icb_cmd_ready,
  output logic                         s_icb_cmd_read,
  output logic [AW-1:0]                s_icb_cmd_addr,
  output logic [31:0]                  s_icb_cmd_wdata,
  output logic [3:0]                   s_icb_cmd_wmask,
  input  logic                         s_icb_rsp_valid,
  output logic                         s_icb_rsp_ready,
  input  logic [31:0]                  s_icb_rsp_rdata,
  input  logic                         s_icb_rsp_err,
  output logic [$clog2(OST_DEPTH):0]   ost_cnt,
  output logic                         unexp_rsp_err
);

  localparam int unsigned PW = $clog2(OST_DEPTH);
  localparam logic [PW:0] DEPTH_CNT = (PW+1)'(OST_DEPTH);

  typedef enum logic {GRANT_FREE, GRANT_LOCKED} lock_t;

  lock_t                lock_q, lock_d;
  logic                 lock_sel_q;
  logic                 last_q;
  logic                 sel, sel_valid;
  logic [OST_DEPTH-1:0] tags;
  logic [PW-1:0]        wptr, rptr;
  logic [PW:0]          cnt;
  logic                 full, empty, head;
  logic                 cmd_hs, rsp_hs;

  // Outputs are gated by the (active-high) reset so nothing handshakes while held.
  always_comb begin
    full = (cnt == DEPTH_CNT);
    if (lock_q == GRANT_LOCKED)                     sel = lock_sel_q;
    else if (m0_icb_cmd_valid && m1_icb_cmd_valid)  sel = ~last_q;
    else                                            sel = m1_icb_cmd_valid & ~m0_icb_cmd_valid;
    sel_valid = sel ? m1_icb_cmd_valid : m0_icb_cmd_valid;

    s_icb_cmd_valid = sel_valid & ~full & ~rst_n;
    s_icb_cmd_read  = sel ? m1_icb_cmd_read  : m0_icb_cmd_read;
    s_icb_cmd_addr  = sel ? m1_icb_cmd_addr  : m0_icb_cmd_addr;
    s_icb_cmd_wdata = sel ? m1_icb_cmd_wdata : m0_icb_cmd_wdata;
    s_icb_cmd_wmask = sel ? m1_icb_cmd_wmask : m0_icb_cmd_wmask;

    m0_icb_cmd_ready = ~sel & s_icb_cmd_ready & ~full & ~rst_n;
    m1_icb_cmd_ready =  sel & s_icb_cmd_ready & ~full & ~rst_n;
    cmd_hs           = s_icb_cmd_valid & s_icb_cmd_ready;
    lock_d           = (s_icb_cmd_valid && !s_icb_cmd_ready) ? GRANT_LOCKED : GRANT_FREE;
  end

  // An empty FIFO still accepts a stray response so the slave never hangs.
  always_comb begin
    empty            = (cnt == '0);
    head             = tags[rptr];
    s_icb_rsp_ready  = ~rst_n & (empty | (head ? m1_icb_rsp_ready : m0_icb_rsp_ready));
    m0_icb_rsp_valid = ~rst_n & ~empty & ~head & s_icb_rsp_valid;
    m1_icb_rsp_valid = ~rst_n & ~empty &  head & s_icb_rsp_valid;
    m0_icb_rsp_rdata = s_icb_rsp_rdata;
    m1_icb_rsp_rdata = s_icb_rsp_rdata;
    m0_icb_rsp_err   = s_icb_rsp_err;
    m1_icb_rsp_err   = s_icb_rsp_err;
    rsp_hs           = s_icb_rsp_valid & s_icb_rsp_ready & ~empty;
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      lock_q        <= GRANT_FREE;
      lock_sel_q    <= 1'b0;
      last_q        <= 1'b1;
      tags          <= '0;
      wptr          <= '0;
      rptr          <= '0;
      cnt           <= '0;
      unexp_rsp_err <= 1'b0;
    end else begin
      lock_q <= lock_d;
      if (lock_d == GRANT_LOCKED) lock_sel_q <= sel;
      if (cmd_hs) begin
        last_q     <= sel;
        tags[wptr] <= sel;
        wptr       <= wptr + PW'(1);
      end
      if (rsp_hs) rptr <= rptr + PW'(1);
      if (cmd_hs && !rsp_hs)      cnt <= cnt + (PW+1)'(1);
      else if (!cmd_hs && rsp_hs) cnt <= cnt - (PW+1)'(1);
      if (s_icb_rsp_valid && empty) unexp_rsp_err <= 1'b1;
    end
  end

  assign ost_cnt = cnt;

endmodule

// File: tb/tb_acc_icb_arb.sv
// Bench for acc_icb_arb: directed scenarios plus random traffic, all checked
// against a queue-based reference of arbitration and in-order response return.
module tb_acc_icb_arb;

  localparam int unsigned OST = 4;
  localparam int unsigned AW  = 32;

  logic clk;
  logic rst_n;
  logic          v [2];
  logic          rd [2];
  logic [AW-1:0] addr [2];
  logic [31:0]   wdata [2];
  logic [3:0]    wm [2];
  logic          rr [2];
  logic          sready, srv, serr;
  logic [31:0]   srdata;

  logic m0_cmd_ready, m1_cmd_ready, m0_rsp_valid, m1_rsp_valid, m0_rsp_err, m1_rsp_err;
  logic [31:0] m0_rsp_rdata, m1_rsp_rdata;
  logic s_cmd_valid, s_cmd_read, s_rsp_ready, unexp;
  logic [AW-1:0] s_cmd_addr;
  logic [31:0] s_cmd_wdata;
  logic [3:0]  s_cmd_wmask;
  logic [$clog2(OST):0] ost_cnt;

  acc_icb_arb #(.OST_DEPTH(OST), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_icb_cmd_valid(v[0]), .m0_icb_cmd_ready(m0_cmd_ready), .m0_icb_cmd_read(rd[0]),
    .m0_icb_cmd_addr(addr[0]), .m0_icb_cmd_wdata(wdata[0]), .m0_icb_cmd_wmask(wm[0]),
    .m0_icb_rsp_valid(m0_rsp_valid), .m0_icb_rsp_ready(rr[0]),
    .m0_icb_rsp_rdata(m0_rsp_rdata), .m0_icb_rsp_err(m0_rsp_err),
    .m1_icb_cmd_valid(v[1]), .m1_icb_cmd_ready(m1_cmd_ready), .m1_icb_cmd_read(rd[1]),
    .m1_icb_cmd_addr(addr[1]), .m1_icb_cmd_wdata(wdata[1]), .m1_icb_cmd_wmask(wm[1]),
    .m1_icb_rsp_valid(m1_rsp_valid), .m1_icb_rsp_ready(rr[1]),
    .m1_icb_rsp_rdata(m1_rsp_rdata), .m1_icb_rsp_err(m1_rsp_err),
    .s_icb_cmd_valid(s_cmd_valid), .s_icb_cmd_ready(sready), .s_icb_cmd_read(s_cmd_read),
    .s_icb_cmd_addr(s_cmd_addr), .s_icb_cmd_wdata(s_cmd_wdata), .s_icb_cmd_wmask(s_cmd_wmask),
    .s_icb_rsp_valid(srv), .s_icb_rsp_ready(s_rsp_ready),
    .s_icb_rsp_rdata(srdata), .s_icb_rsp_err(serr),
    .ost_cnt(ost_cnt), .unexp_rsp_err(unexp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference state: who was granted last, a pending (stalled) grant, the
  // in-order list of issuers, and the data each requester should get back.
  bit          last_g, lk, lk_g, unexp_m;
  int          tagq[$];
  logic [31:0] sq[$];
  logic [31:0] eq0[$], eq1[$];
  bit          hold [2];
  bit          shold;
  bit          acc [2];
  bit          rand_data;
  logic [31:0] nxt_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    last_g = 1'b1; lk = 1'b0; lk_g = 1'b0; unexp_m = 1'b0;
    tagq.delete(); sq.delete(); eq0.delete(); eq1.delete();
    hold[0] = 1'b0; hold[1] = 1'b0; shold = 1'b0;
  endtask

  task automatic set_idle();
    for (int n = 0; n < 2; n++) begin
      v[n] = 1'b0; rd[n] = 1'b0; addr[n] = '0; wdata[n] = '0; wm[n] = '0; rr[n] = 1'b1;
      hold[n] = 1'b0;
    end
    sready = 1'b1; srv = 1'b0; serr = 1'b0; shold = 1'b0;
  endtask

  // One clock cycle: starts just after a rising edge, checks combinational
  // behaviour mid-cycle, then advances the reference at the edge.
  task automatic cycle();
    bit full, empty, g, h, gv, esv, hs, rhs, ersr;
    logic [31:0] data;
    srdata = (sq.size() > 0) ? sq[0] : 32'hDEAD_BEEF;
    #2;
    full = (tagq.size() == OST);
    if (lk)              g = lk_g;
    else if (v[0] && v[1]) g = !last_g;
    else if (v[1])       g = 1'b1;
    else                 g = 1'b0;
    gv  = g ? v[1] : v[0];
    esv = gv && !full;
    chk("s_cmd_valid", s_cmd_valid, esv);
    if (esv) begin
      chk("s_cmd_addr", s_cmd_addr, addr[g]);
      chk("s_cmd_wdata", s_cmd_wdata, wdata[g]);
      chk("s_cmd_read", s_cmd_read, rd[g]);
    end
    if (v[0] || v[1]) begin
      chk("m0_cmd_ready", m0_cmd_ready, !g && sready && !full);
      chk("m1_cmd_ready", m1_cmd_ready, g && sready && !full);
    end
    empty = (tagq.size() == 0);
    h     = empty ? 1'b0 : tagq[0][0];
    ersr  = empty ? 1'b1 : rr[h];
    chk("s_rsp_ready", s_rsp_ready, ersr);
    chk("m0_rsp_valid", m0_rsp_valid, !empty && !h && srv);
    chk("m1_rsp_valid", m1_rsp_valid, !empty && h && srv);
    hs  = esv && sready;
    rhs = srv && !empty && ersr;
    if (rhs && !h) begin
      chk("m0_rsp_rdata", m0_rsp_rdata, eq0.pop_front());
      chk("m0_rsp_err", m0_rsp_err, serr);
    end
    if (rhs && h) begin
      chk("m1_rsp_rdata", m1_rsp_rdata, eq1.pop_front());
      chk("m1_rsp_err", m1_rsp_err, serr);
    end
    @(posedge clk);
    if (srv && empty) unexp_m = 1'b1;
    if (rhs) begin
      void'(tagq.pop_front());
      void'(sq.pop_front());
    end
    if (hs) begin
      data = rand_data ? $urandom : nxt_data;
      nxt_data = nxt_data + 1;
      tagq.push_back(int'(g));
      sq.push_back(data);
      if (g) eq1.push_back(data); else eq0.push_back(data);
      last_g = g;
    end
    lk   = esv && !sready;
    lk_g = g;
    acc[0] = hs && !g;
    acc[1] = hs && g;
    hold[0] = v[0] && !acc[0];
    hold[1] = v[1] && !acc[1];
    shold   = srv && !rhs;
    #1;
    chk("ost_cnt", ost_cnt, tagq.size());
    chk("unexp_rsp_err", unexp, unexp_m);
  endtask

  // Asserts reset mid-cycle; outputs must drop immediately.
  task automatic do_reset();
    rst_n = 1'b1;
    #1;
    chk("rst_s_cmd_valid", s_cmd_valid, 1'b0);
    chk("rst_m0_cmd_ready", m0_cmd_ready, 1'b0);
    chk("rst_m1_cmd_ready", m1_cmd_ready, 1'b0);
    chk("rst_m0_rsp_valid", m0_rsp_valid, 1'b0);
    chk("rst_m1_rsp_valid", m1_rsp_valid, 1'b0);
    chk("rst_s_rsp_ready", s_rsp_ready, 1'b0);
    chk("rst_ost_cnt", ost_cnt, 0);
    chk("rst_unexp", unexp, 1'b0);
    model_clear();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
  endtask

  task automatic drain();
    set_idle();
    for (int i = 0; i < 40 && sq.size() > 0; i++) begin
      srv = 1'b1;
      cycle();
    end
    srv = 1'b0; shold = 1'b0;
    chk("drain_ost", ost_cnt, 0);
  endtask

  task automatic gen_random();
    for (int n = 0; n < 2; n++) begin
      if (!hold[n]) begin
        v[n]     = ($urandom_range(0, 99) < 60);
        rd[n]    = 1'($urandom);
        addr[n]  = $urandom & 32'hFFFF_FFFC;
        wdata[n] = $urandom;
        wm[n]    = 4'($urandom);
      end
      rr[n] = ($urandom_range(0, 99) < 70);
    end
    sready = ($urandom_range(0, 99) < 70);
    if (!shold) begin
      srv  = (sq.size() > 0) && ($urandom_range(0, 99) < 60);
      serr = 1'($urandom);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst_n = 1'b0;
    rand_data = 1'b1;
    nxt_data = '0;
    set_idle();
    model_clear();
    #6;
    do_reset();

    // Stalled grant to m1 must hold while m0 shows up, then m0 goes next.
    v[1] = 1'b1; addr[1] = 32'h200; sready = 1'b0;
    cycle();
    v[0] = 1'b1; addr[0] = 32'h100;
    cycle();
    #1 chk("lock_addr_m1", s_cmd_addr, 32'h200);
    cycle();
    sready = 1'b1;
    cycle();
    v[1] = 1'b0;
    #1 chk("after_lock_m0", s_cmd_addr, 32'h100);
    cycle();
    v[0] = 1'b0;
    drain();

    // Silent slave: four commands fill the FIFO, the fifth waits for a pop.
    set_idle();
    k = 0;
    for (int i = 0; i < 6; i++) begin
      v[0] = 1'b1; addr[0] = 32'h1000 + 32'(4 * k);
      cycle();
      if (acc[0]) k++;
    end
    chk("full_ost", ost_cnt, 4);
    chk("full_blocked", s_cmd_valid, 1'b0);
    srv = 1'b1;
    cycle();
    srv = 1'b0;
    cycle();
    chk("fifth_accepted", ost_cnt, 4);
    drain();

    // In-order returns with m1 stalling its response for two cycles.
    rand_data = 1'b0; nxt_data = 32'hA;
    set_idle();
    v[0] = 1'b1; addr[0] = 32'h100; cycle();
    v[0] = 1'b0; v[1] = 1'b1; addr[1] = 32'h200; cycle();
    v[1] = 1'b0; v[0] = 1'b1; addr[0] = 32'h104; cycle();
    v[0] = 1'b0; hold[0] = 1'b0;
    chk("three_out", ost_cnt, 3);
    srv = 1'b1; rr[0] = 1'b1; rr[1] = 1'b0;
    cycle();
    cycle();
    cycle();
    rr[1] = 1'b1;
    cycle();
    cycle();
    srv = 1'b0;
    rand_data = 1'b1;
    chk("ordered_done", ost_cnt, 0);

    // Stray response with nothing outstanding.
    set_idle();
    srv = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    srv = 1'b0; shold = 1'b0;
    cycle();
    chk("unexp_sticky", unexp, 1'b1);

    for (int i = 0; i < 1500; i++) begin
      gen_random();
      cycle();
    end
    drain();

    // Reset with three outstanding, then the first tie goes to m0.
    set_idle();
    v[0] = 1'b1; addr[0] = 32'h10; cycle();
    v[0] = 1'b0; v[1] = 1'b1; addr[1] = 32'h20; cycle();
    v[1] = 1'b0; v[0] = 1'b1; addr[0] = 32'h14; cycle();
    chk("pre_reset_ost", ost_cnt, 3);
    v[0] = 1'b1; v[1] = 1'b1; srv = 1'b1;
    do_reset();
    srv = 1'b0; addr[0] = 32'h300; addr[1] = 32'h400;
    #1 chk("post_reset_tie", s_cmd_addr, 32'h300);
    cycle();
    cycle();
    set_idle();
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
